// File: rtl/spi_master_cfg.sv
// spi_master_cfg: parametrised full-duplex SPI master with per-transfer mode and bit order.
// Ports: clk/rst (sync, active-high); start/din/cs_sel/cpol/cpha/lsb_first request a
// transfer when ready=1; dout/done report the received word; sclk/mosi/miso/cs_n form
// the SPI bus (cs_n active-low, one-hot).
module spi_master_cfg #(
    parameter int DATA_W  = 8,
    parameter int CLK_DIV = 4,
    parameter int NUM_CS  = 4,
    parameter int SEL_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [DATA_W-1:0] din,
    input  logic [SEL_W-1:0]  cs_sel,
    input  logic              cpol,
    input  logic              cpha,
    input  logic              lsb_first,
    input  logic              miso,
    output logic              ready,
    output logic [DATA_W-1:0] dout,
    output logic              done,
    output logic              sclk,
    output logic              mosi,
    output logic [NUM_CS-1:0] cs_n
);
    localparam int CW = $clog2(CLK_DIV);
    localparam int EW = $clog2(2 * DATA_W);

    typedef enum logic [1:0] {IDLE, LEAD, XFER, TRAIL} state_t;

    state_t            state;
    logic [CW-1:0]     cnt;
    logic [EW-1:0]     ec;
    logic [DATA_W-1:0] tx;
    logic [DATA_W-1:0] rx;
    logic              cpol_q;
    logic              cpha_q;
    logic              lsb_q;
    logic              tick;
    logic              accept;

    function automatic logic first_bit(input logic [DATA_W-1:0] v, input logic l);
        return l ? v[0] : v[DATA_W-1];
    endfunction

    function automatic logic [DATA_W-1:0] drop_bit(input logic [DATA_W-1:0] v, input logic l);
        return l ? v >> 1 : v << 1;
    endfunction

    assign tick   = cnt == CW'(CLK_DIV - 1);
    assign accept = start && ready && ({1'b0, cs_sel} < (SEL_W + 1)'(NUM_CS));

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            ready  <= 1'b1;
            done   <= 1'b0;
            dout   <= '0;
            sclk   <= 1'b0;
            mosi   <= 1'b0;
            cs_n   <= '1;
            cnt    <= '0;
            ec     <= '0;
            tx     <= '0;
            rx     <= '0;
            cpol_q <= 1'b0;
            cpha_q <= 1'b0;
            lsb_q  <= 1'b0;
        end else begin
            done  <= 1'b0;
            ready <= (state == IDLE) && !accept;
            // The divider is held at zero while idle so each transfer starts from a clean phase.
            cnt   <= (state == IDLE || tick) ? '0 : cnt + CW'(1);
            case (state)
                IDLE: begin
                    sclk <= cpol;
                    mosi <= (accept && !cpha) ? first_bit(din, lsb_first) : 1'b0;
                    if (accept) begin
                        state  <= LEAD;
                        cs_n   <= ~(NUM_CS'(1) << cs_sel);
                        cpol_q <= cpol;
                        cpha_q <= cpha;
                        lsb_q  <= lsb_first;
                        ec     <= '0;
                        rx     <= '0;
                        // With cpha=0 the first bit is already on mosi, so it leaves tx now.
                        tx     <= cpha ? din : drop_bit(din, lsb_first);
                    end
                end
                LEAD: begin
                    sclk <= cpol_q;
                    if (tick) state <= XFER;
                end
                XFER: begin
                    if (tick) begin
                        sclk <= ~sclk;
                        ec   <= ec + EW'(1);
                        // ec even = leading edge; cpha selects whether leading edges sample or drive.
                        if (ec[0] == cpha_q)
                            rx <= lsb_q ? {miso, rx[DATA_W-1:1]} : {rx[DATA_W-2:0], miso};
                        else if (ec != EW'(2 * DATA_W - 1)) begin
                            mosi <= first_bit(tx, lsb_q);
                            tx   <= drop_bit(tx, lsb_q);
                        end
                        if (ec == EW'(2 * DATA_W - 1)) state <= TRAIL;
                    end
                end
                TRAIL: begin
                    if (tick) begin
                        state <= IDLE;
                        cs_n  <= '1;
                        done  <= 1'b1;
                        dout  <= rx;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_spi_master_cfg.sv
// tb_spi_master_cfg: directed self-checking bench for spi_master_cfg (default and 16-bit instances).
module tb_spi_master_cfg;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    int          vec = 0;
    int          errs = 0;

    logic        start0 = 1'b0, cpol0 = 1'b0, cpha0 = 1'b0, lsb0 = 1'b1, miso0;
    logic [7:0]  din0 = '0;
    logic [1:0]  sel0 = '0;
    logic        ready0, done0, sclk0, mosi0;
    logic [7:0]  dout0;
    logic [3:0]  cs_n0;
    logic        loop0 = 1'b1, slv = 1'b0, sprev = 1'b0;
    logic [7:0]  sword = 8'hC3;
    int          sidx = 0;

    logic        start1 = 1'b0, cpol1 = 1'b0, cpha1 = 1'b0, lsb1 = 1'b1;
    logic [15:0] din1 = '0;
    logic [2:0]  sel1 = '0;
    logic        ready1, done1, sclk1, mosi1;
    logic [15:0] dout1;
    logic [4:0]  cs_n1;

    assign miso0 = loop0 ? mosi0 : slv;

    always #5 clk = ~clk;

    spi_master_cfg u0 (
        .clk(clk), .rst(rst), .start(start0), .din(din0), .cs_sel(sel0), .cpol(cpol0),
        .cpha(cpha0), .lsb_first(lsb0), .miso(miso0), .ready(ready0), .dout(dout0),
        .done(done0), .sclk(sclk0), .mosi(mosi0), .cs_n(cs_n0)
    );

    spi_master_cfg #(.DATA_W(16), .CLK_DIV(2), .NUM_CS(5)) u1 (
        .clk(clk), .rst(rst), .start(start1), .din(din1), .cs_sel(sel1), .cpol(cpol1),
        .cpha(cpha1), .lsb_first(lsb1), .miso(mosi1), .ready(ready1), .dout(dout1),
        .done(done1), .sclk(sclk1), .mosi(mosi1), .cs_n(cs_n1)
    );

    // Slave model: presents the next MSB-first bit of sword after each leading edge.
    always @(negedge clk) begin
        if (cs_n0 == 4'hF) begin
            sidx <= 0;
            slv  <= 1'b0;
        end else if (sclk0 != sprev && sclk0 != cpol0 && sidx < 8) begin
            slv  <= sword[7 - sidx];
            sidx <= sidx + 1;
        end
        sprev <= sclk0;
    end

    task automatic xfer0(input logic [7:0] d, input logic [1:0] s, input logic p, input logic h,
                         input logic l, output int n, output logic [7:0] bits, output int edges,
                         output int bad, output logic [3:0] cs_mid);
        logic ps, pm;
        din0 = d; sel0 = s; cpol0 = p; cpha0 = h; lsb0 = l;
        repeat (3) @(negedge clk);
        ps = sclk0; pm = mosi0;
        start0 = 1'b1;
        @(posedge clk);
        n = 0; bits = '0; edges = 0; bad = 0; cs_mid = '1;
        while (n < 300) begin
            @(negedge clk);
            n++;
            start0 = 1'b0;
            if (n == 10) cs_mid = cs_n0;
            if (sclk0 != ps) begin
                edges++;
                if ((sclk0 != p) == !h) bits = {mosi0, bits[7:1]};
            end
            if (n > 1 && mosi0 != pm && !(sclk0 != ps && ((sclk0 == p) == !h))) bad++;
            ps = sclk0; pm = mosi0;
            if (done0) break;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        vec++; if (ready0 !== 1'b1) begin errs++; $display("FAIL reset_ready got %b want 1", ready0); end
        vec++; if (done0 !== 1'b0) begin errs++; $display("FAIL reset_done got %b want 0", done0); end
        vec++; if (dout0 !== 8'h00) begin errs++; $display("FAIL reset_dout got %h want 00", dout0); end
        vec++; if (sclk0 !== 1'b0) begin errs++; $display("FAIL reset_sclk got %b want 0", sclk0); end
        vec++; if (mosi0 !== 1'b0) begin errs++; $display("FAIL reset_mosi got %b want 0", mosi0); end
        vec++; if (cs_n0 !== 4'hF) begin errs++; $display("FAIL reset_cs_n got %h want f", cs_n0); end
        vec++; if (cs_n1 !== 5'h1F) begin errs++; $display("FAIL reset_cs_n1 got %h want 1f", cs_n1); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_mode0();
        int n, edges, bad; logic [7:0] bits; logic [3:0] cm;
        loop0 = 1'b1;
        xfer0(8'hA5, 2'd2, 1'b0, 1'b0, 1'b1, n, bits, edges, bad, cm);
        vec++; if (cm !== 4'b1011) begin errs++; $display("FAIL m0_cs_n got %b want 1011", cm); end
        vec++; if (bits !== 8'hA5) begin errs++; $display("FAIL m0_mosi_bits got %h want a5", bits); end
        vec++; if (n !== 73) begin errs++; $display("FAIL m0_latency got %0d want 73", n); end
        vec++; if (dout0 !== 8'hA5) begin errs++; $display("FAIL m0_dout got %h want a5", dout0); end
        vec++; if (edges !== 16) begin errs++; $display("FAIL m0_edges got %0d want 16", edges); end
        vec++; if (cs_n0 !== 4'hF) begin errs++; $display("FAIL m0_cs_n_done got %h want f", cs_n0); end
        vec++; if (ready0 !== 1'b0) begin errs++; $display("FAIL m0_ready_done got %b want 0", ready0); end
        @(negedge clk);
        vec++; if (ready0 !== 1'b1) begin errs++; $display("FAIL m0_ready_after got %b want 1", ready0); end
    endtask

    task automatic test_mode3();
        int n, edges, bad; logic [7:0] bits; logic [3:0] cm;
        loop0 = 1'b0;
        xfer0(8'h3C, 2'd1, 1'b1, 1'b1, 1'b0, n, bits, edges, bad, cm);
        vec++; if (dout0 !== 8'hC3) begin errs++; $display("FAIL m3_dout got %h want c3", dout0); end
        vec++; if (edges !== 16) begin errs++; $display("FAIL m3_edges got %0d want 16", edges); end
        vec++; if (bits !== 8'h3C) begin errs++; $display("FAIL m3_mosi_bits got %h want 3c", bits); end
        vec++; if (cm !== 4'b1101) begin errs++; $display("FAIL m3_cs_n got %b want 1101", cm); end
        repeat (3) @(negedge clk);
        vec++; if (sclk0 !== 1'b1) begin errs++; $display("FAIL m3_sclk_idle got %b want 1", sclk0); end
        loop0 = 1'b1;
    endtask

    task automatic test_modes12();
        int n, edges, bad; logic [7:0] bits; logic [3:0] cm;
        xfer0(8'h81, 2'd3, 1'b0, 1'b1, 1'b0, n, bits, edges, bad, cm);
        vec++; if (dout0 !== 8'h81) begin errs++; $display("FAIL m1_dout got %h want 81", dout0); end
        vec++; if (bad !== 0) begin errs++; $display("FAIL m1_mosi_edges got %0d want 0", bad); end
        vec++; if (n !== 73) begin errs++; $display("FAIL m1_latency got %0d want 73", n); end
        xfer0(8'h81, 2'd0, 1'b1, 1'b0, 1'b1, n, bits, edges, bad, cm);
        vec++; if (dout0 !== 8'h81) begin errs++; $display("FAIL m2_dout got %h want 81", dout0); end
        vec++; if (bad !== 0) begin errs++; $display("FAIL m2_mosi_edges got %0d want 0", bad); end
        vec++; if (edges !== 16) begin errs++; $display("FAIL m2_edges got %0d want 16", edges); end
    endtask

    task automatic test_back_to_back();
        int dcnt = 0, t1 = 0, t2 = 0, hi = 0;
        din0 = 8'h5A; sel0 = 2'd0; cpol0 = 1'b0; cpha0 = 1'b0; lsb0 = 1'b1;
        repeat (3) @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        for (int n = 1; n <= 230; n++) begin
            @(negedge clk);
            if (n == 200) start0 = 1'b0;
            if (done0) begin
                dcnt++;
                if (dcnt == 1) t1 = n;
                if (dcnt == 2) t2 = n;
            end
            if (n >= 73 && n < 147 && cs_n0[0]) hi++;
            if (n == 147) begin
                vec++; if (dcnt !== 2) begin errs++; $display("FAIL b2b_count147 got %0d want 2", dcnt); end
            end
            if (n == 74) begin
                vec++; if (ready0 !== 1'b1) begin errs++; $display("FAIL b2b_ready74 got %b want 1", ready0); end
            end
        end
        vec++; if (t1 !== 73) begin errs++; $display("FAIL b2b_done1 got %0d want 73", t1); end
        vec++; if (t2 !== 147) begin errs++; $display("FAIL b2b_done2 got %0d want 147", t2); end
        vec++; if (hi !== 2) begin errs++; $display("FAIL b2b_cs_high got %0d want 2", hi); end
        vec++; if (dcnt !== 3) begin errs++; $display("FAIL b2b_total got %0d want 3", dcnt); end
        vec++; if (dout0 !== 8'h5A) begin errs++; $display("FAIL b2b_dout got %h want 5a", dout0); end
    endtask

    task automatic test_abort();
        int n, edges, bad; logic [7:0] bits; logic [3:0] cm;
        din0 = 8'h66; sel0 = 2'd1; cpol0 = 1'b0; cpha0 = 1'b0; lsb0 = 1'b1;
        repeat (3) @(negedge clk);
        start0 = 1'b1;
        @(posedge clk);
        for (int i = 1; i <= 30; i++) begin
            @(negedge clk);
            start0 = 1'b0;
        end
        rst = 1'b1;
        @(negedge clk);
        vec++; if (cs_n0 !== 4'hF) begin errs++; $display("FAIL abort_cs_n got %h want f", cs_n0); end
        vec++; if (sclk0 !== 1'b0) begin errs++; $display("FAIL abort_sclk got %b want 0", sclk0); end
        vec++; if (ready0 !== 1'b1) begin errs++; $display("FAIL abort_ready got %b want 1", ready0); end
        vec++; if (done0 !== 1'b0) begin errs++; $display("FAIL abort_done got %b want 0", done0); end
        vec++; if (dout0 !== 8'h00) begin errs++; $display("FAIL abort_dout got %h want 00", dout0); end
        rst = 1'b0;
        xfer0(8'h96, 2'd1, 1'b0, 1'b0, 1'b1, n, bits, edges, bad, cm);
        vec++; if (n !== 73) begin errs++; $display("FAIL abort_relatency got %0d want 73", n); end
        vec++; if (dout0 !== 8'h96) begin errs++; $display("FAIL abort_redout got %h want 96", dout0); end
    endtask

    task automatic test_wide_invalid();
        int dn = 0, low = 0, n = 0;
        logic [4:0] cm = '1;
        din1 = 16'h1234; sel1 = 3'd5;
        @(negedge clk);
        start1 = 1'b1;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (i == 2) start1 = 1'b0;
            if (done1) dn++;
            if (cs_n1 !== 5'h1F) low++;
        end
        vec++; if (dn !== 0) begin errs++; $display("FAIL inv_done got %0d want 0", dn); end
        vec++; if (low !== 0) begin errs++; $display("FAIL inv_cs_n got %0d want 0", low); end
        vec++; if (ready1 !== 1'b1) begin errs++; $display("FAIL inv_ready got %b want 1", ready1); end
        din1 = 16'hBEEF; sel1 = 3'd1;
        @(negedge clk);
        start1 = 1'b1;
        @(posedge clk);
        while (n < 200) begin
            @(negedge clk);
            n++;
            start1 = 1'b0;
            if (n == 10) cm = cs_n1;
            if (done1) break;
        end
        vec++; if (cm !== 5'b11101) begin errs++; $display("FAIL w16_cs_n got %b want 11101", cm); end
        vec++; if (n !== 69) begin errs++; $display("FAIL w16_latency got %0d want 69", n); end
        vec++; if (dout1 !== 16'hBEEF) begin errs++; $display("FAIL w16_dout got %h want beef", dout1); end
    endtask

    initial begin
        test_reset();
        test_mode0();
        test_mode3();
        test_modes12();
        test_back_to_back();
        test_abort();
        test_wide_invalid();
        $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
        $finish;
    end
endmodule
